// File: rtl/slow_control_readback.sv
// slow_control_readback: samples MICROROC SR_OUT on SR_CK rises and packs MSB-first 16-bit words for an external FIFO.
// Define READBACK_CRC_EN to add a CRC-16-CCITT of the returned stream on ReadbackCrc.
module slow_control_readback #(
    parameter int SC_BITS        = 592,
    parameter int RS_BITS        = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        SlowControlOrReadScopeSelect,
    input  logic        ReadbackStart,
    input  logic        SerialClock,
    input  logic        SerialReset,
    input  logic        SerialDataIn,
    output logic        ExternalFifoWriteEn,
    output logic [15:0] ExternalFifoData,
    output logic        ReadbackBusy,
    output logic        ReadbackDone,
    output logic        ReadbackTimeout
`ifdef READBACK_CRC_EN
    ,
    output logic [15:0] ReadbackCrc
`endif
);
    localparam int MAX_BITS = SC_BITS > RS_BITS ? SC_BITS : RS_BITS;
    localparam int BW = $clog2(MAX_BITS + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] SC_LEN = BW'(SC_BITS);
    localparam logic [BW-1:0] RS_LEN = BW'(RS_BITS);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;
    state_t state, nextState;

    logic [1:0] clkSync, rstSync, datSync;
    logic clkPrev;
    logic [BW-1:0] bitCnt, bitLen;
    logic [3:0] wordCnt;
    logic [15:0] shiftReg;
    logic [WW-1:0] watchdog;
    logic pendWrite, flushWrite;
    logic rise, accept, serialRst, shiftEn, lastBit, expired;

    assign rise = clkSync[1] & ~clkPrev;
    assign accept = state == IDLE && ReadbackStart;
    assign serialRst = state == SHIFT && !rstSync[1];
    assign shiftEn = state == SHIFT && rstSync[1] && rise;
    assign lastBit = shiftEn && bitCnt + BW'(1) == bitLen;
    assign expired = state == SHIFT && !rise && watchdog == WD_LAST;

    always_ff @(posedge Clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state == IDLE  ? (ReadbackStart ? SHIFT : IDLE) :
                    state == SHIFT ? (expired ? IDLE : lastBit ? FLUSH : SHIFT) :
                    state == FLUSH ? DONE : IDLE;
    end

    // After the last bit wordCnt holds N mod 16, so a nonzero value means a partial word remains
    always_comb begin
        ReadbackBusy = state != IDLE;
        flushWrite = state == FLUSH && wordCnt != 4'd0;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            clkSync <= '0;
            rstSync <= '1;
            datSync <= '0;
            clkPrev <= 1'b0;
            bitLen <= '0;
            bitCnt <= '0;
            wordCnt <= '0;
            shiftReg <= '0;
            watchdog <= '0;
            pendWrite <= 1'b0;
            ExternalFifoWriteEn <= 1'b0;
            ExternalFifoData <= '0;
            ReadbackDone <= 1'b0;
            ReadbackTimeout <= 1'b0;
        end else begin
            clkSync <= {clkSync[0], SerialClock};
            rstSync <= {rstSync[0], SerialReset};
            datSync <= {datSync[0], SerialDataIn};
            clkPrev <= clkSync[1];
            pendWrite <= shiftEn && wordCnt == 4'd15;
            ExternalFifoWriteEn <= pendWrite || flushWrite;
            ExternalFifoData <= pendWrite ? shiftReg :
                                flushWrite ? shiftReg << (5'd16 - {1'b0, wordCnt}) : ExternalFifoData;
            ReadbackDone <= state == DONE;
            ReadbackTimeout <= expired;
            watchdog <= (accept || rise) ? '0 : state == SHIFT ? watchdog + WW'(1) : watchdog;
            if (accept)
                bitLen <= SlowControlOrReadScopeSelect ? SC_LEN : RS_LEN;
            if (accept || serialRst) begin
                bitCnt <= '0;
                wordCnt <= '0;
                shiftReg <= '0;
            end else if (shiftEn) begin
                bitCnt <= bitCnt + BW'(1);
                wordCnt <= wordCnt + 4'd1;
                shiftReg <= {shiftReg[14:0], datSync[1]};
            end
        end
    end

`ifdef READBACK_CRC_EN
    logic [15:0] crc, crcNext;

    assign crcNext = {crc[14:0], 1'b0} ^ ((crc[15] ^ datSync[1]) ? 16'h1021 : 16'h0000);
    assign ReadbackCrc = crc;

    always_ff @(posedge Clk) begin
        if (reset || accept || serialRst)
            crc <= '0;
        else if (shiftEn)
            crc <= crcNext;
    end
`endif
endmodule

// File: tb/tb_slow_control_readback.sv
// tb_slow_control_readback: two instances (read scope 64 and 20 bits) driven by shared serial stimulus,
// checked against a bit-stream packing model; CRC checks are added when READBACK_CRC_EN is defined.
module tb_slow_control_readback;
    localparam int SC   = 592;
    localparam int RS_A = 64;
    localparam int RS_B = 20;
    localparam int TO   = 4096;

    logic Clk = 1'b0, reset = 1'b1, sel = 1'b0, start = 1'b0;
    logic sck = 1'b0, srst = 1'b1, sdin = 1'b0;
    logic weA, weB, busyA, busyB, doneA, doneB, toA, toB;
    logic [15:0] dataA, dataB;
`ifdef READBACK_CRC_EN
    logic [15:0] crcA, crcB;
`endif

    int cyc = 0, checks = 0, errors = 0;
    int nWrA, nWrB, nDoneA, nDoneB, nToA, nToB, doneCycA, doneCycB, toCycA, toCycB;
    int rises[$];
    logic [15:0] qA[$], qB[$];
    bit bits[$];

    always #5 Clk = ~Clk;

    slow_control_readback #(.SC_BITS(SC), .RS_BITS(RS_A), .TIMEOUT_CYCLES(TO)) dutA (
        .Clk(Clk), .reset(reset), .SlowControlOrReadScopeSelect(sel), .ReadbackStart(start),
        .SerialClock(sck), .SerialReset(srst), .SerialDataIn(sdin),
        .ExternalFifoWriteEn(weA), .ExternalFifoData(dataA), .ReadbackBusy(busyA),
        .ReadbackDone(doneA), .ReadbackTimeout(toA)
`ifdef READBACK_CRC_EN
        , .ReadbackCrc(crcA)
`endif
    );

    slow_control_readback #(.SC_BITS(SC), .RS_BITS(RS_B), .TIMEOUT_CYCLES(TO)) dutB (
        .Clk(Clk), .reset(reset), .SlowControlOrReadScopeSelect(sel), .ReadbackStart(start),
        .SerialClock(sck), .SerialReset(srst), .SerialDataIn(sdin),
        .ExternalFifoWriteEn(weB), .ExternalFifoData(dataB), .ReadbackBusy(busyB),
        .ReadbackDone(doneB), .ReadbackTimeout(toB)
`ifdef READBACK_CRC_EN
        , .ReadbackCrc(crcB)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected FIFO words: the counted bit stream cut into 16-bit chunks, last one zero-padded
    task automatic pushWords(input int which, input int n);
        logic [15:0] w;
        for (int i = 0; i < n; i += 16) begin
            w = '0;
            for (int j = 0; j < 16; j++)
                if (i + j < n) w[15 - j] = bits[i + j];
            if (which == 0) qA.push_back(w);
            else qB.push_back(w);
        end
    endtask

`ifdef READBACK_CRC_EN
    function automatic logic [15:0] crcOf(input int n);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < n; i++)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ bits[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction
`endif

    task automatic step();
        logic [16:0] e;
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
        if (weA) begin
            nWrA++;
            e = qA.size() > 0 ? {1'b0, qA.pop_front()} : 17'h10000;
            chk("wordA", {16'b0, dataA}, {15'b0, e});
        end
        if (weB) begin
            nWrB++;
            e = qB.size() > 0 ? {1'b0, qB.pop_front()} : 17'h10000;
            chk("wordB", {16'b0, dataB}, {15'b0, e});
        end
        if (doneA) begin nDoneA++; doneCycA = cyc; end
        if (doneB) begin nDoneB++; doneCycB = cyc; end
        if (toA) begin nToA++; toCycA = cyc; end
        if (toB) begin nToB++; toCycB = cyc; end
    endtask

    task automatic sendBit(input bit b);
        sck = 1'b0;
        sdin = b;
        repeat (4) step();
        sck = 1'b1;
        rises.push_back(cyc);
        repeat (4) step();
    endtask

    task automatic startRun(input logic s, input string tag);
        nWrA = 0; nWrB = 0; nDoneA = 0; nDoneB = 0; nToA = 0; nToB = 0;
        doneCycA = -1; doneCycB = -1; toCycA = -1; toCycB = -1;
        rises.delete();
        sel = s;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busyA"}, busyA, 1);
        chk({tag, "_busyB"}, busyB, 1);
`ifdef READBACK_CRC_EN
        chk({tag, "_crcClear"}, crcA, 0);
`endif
    endtask

    // Done must pulse exactly once, 5 Clk cycles after the pin rise carrying the last bit
    task automatic endChecks(input string tag, input int nA, input int nB);
        repeat (12) step();
        chk({tag, "_writesA"}, nWrA, (nA + 15) / 16);
        chk({tag, "_writesB"}, nWrB, (nB + 15) / 16);
        chk({tag, "_leftA"}, qA.size(), 0);
        chk({tag, "_leftB"}, qB.size(), 0);
        chk({tag, "_doneA"}, nDoneA, 1);
        chk({tag, "_doneB"}, nDoneB, 1);
        chk({tag, "_doneCycA"}, doneCycA, rises[nA - 1] + 5);
        chk({tag, "_doneCycB"}, doneCycB, rises[nB - 1] + 5);
        chk({tag, "_noTimeout"}, nToA + nToB, 0);
        chk({tag, "_idle"}, {busyA, busyB}, 0);
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_we", weA, 0);
        chk("rst_data", dataA, 0);
        chk("rst_busy", busyA, 0);
        chk("rst_done", doneA, 0);
        chk("rst_to", toA, 0);
`ifdef READBACK_CRC_EN
        chk("rst_crc", crcA, 0);
`endif

        // Slow control 1,0,1,0...; a second start at bit 100 must be ignored
        bits.delete();
        for (int i = 0; i < SC; i++) bits.push_back(~i[0]);
        pushWords(0, SC);
        pushWords(1, SC);
        startRun(1'b1, "scAlt");
        for (int i = 0; i < SC; i++) begin
            if (i == 100) begin start = 1'b1; step(); start = 1'b0; end
            sendBit(bits[i]);
        end
        endChecks("scAlt", SC, SC);

        // Read scope all ones; instance B stops after 20 bits and ignores the rest
        bits.delete();
        for (int i = 0; i < RS_A; i++) bits.push_back(1'b1);
        pushWords(0, RS_A);
        pushWords(1, RS_B);
        startRun(1'b0, "rsOnes");
        for (int i = 0; i < RS_A; i++) sendBit(bits[i]);
        endChecks("rsOnes", RS_A, RS_B);

        // Partial word: 0xABCDE then zeros
        bits.delete();
        for (int i = 0; i < RS_A; i++) begin
            logic [19:0] pat;
            pat = 20'hABCDE;
            bits.push_back(i < 20 ? pat[19 - i] : 1'b0);
        end
        pushWords(0, RS_A);
        pushWords(1, RS_B);
        startRun(1'b0, "partial");
        for (int i = 0; i < RS_A; i++) sendBit(bits[i]);
        endChecks("partial", RS_A, RS_B);

        // Random and all-zero read-scope streams
        for (int r = 0; r < 2; r++) begin
            bits.delete();
            for (int i = 0; i < RS_A; i++) bits.push_back(r == 0 ? 1'($urandom_range(0, 1)) : 1'b0);
            pushWords(0, RS_A);
            pushWords(1, RS_B);
            startRun(1'b0, "rsRand");
            for (int i = 0; i < RS_A; i++) sendBit(bits[i]);
            endChecks("rsRand", RS_A, RS_B);
`ifdef READBACK_CRC_EN
            chk("crcA", crcA, {16'b0, crcOf(RS_A)});
            chk("crcB", crcB, {16'b0, crcOf(RS_B)});
`endif
        end

        // SR_RSTB low after 10 ones/random bits discards them
        bits.delete();
        for (int i = 0; i < SC; i++) bits.push_back(1'b0);
        pushWords(0, SC);
        pushWords(1, SC);
        startRun(1'b1, "srst");
        for (int i = 0; i < 10; i++) sendBit(i == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
        srst = 1'b0;
        repeat (6) step();
        srst = 1'b1;
        repeat (6) step();
        rises.delete();
        for (int i = 0; i < SC; i++) sendBit(bits[i]);
        endChecks("srst", SC, SC);
`ifdef READBACK_CRC_EN
        chk("srst_crc", crcA, 0);
`endif

        // Watchdog: 5 edges then SR_CK idle
        startRun(1'b0, "wdog");
        for (int i = 0; i < 5; i++) sendBit(1'($urandom_range(0, 1)));
        for (int i = 0; i < TO + 200 && nToA == 0; i++) step();
        repeat (4) step();
        chk("wdog_cycA", toCycA, rises[4] + 3 + TO);
        chk("wdog_cycB", toCycB, rises[4] + 3 + TO);
        chk("wdog_pulses", nToA, 1);
        chk("wdog_writes", nWrA + nWrB, 0);
        chk("wdog_done", nDoneA + nDoneB, 0);
        chk("wdog_busy", {busyA, busyB}, 0);

        // Reset at bit 300: only the 18 complete words written, nothing afterwards
        bits.delete();
        for (int i = 0; i < 300; i++) bits.push_back(1'($urandom_range(0, 1)));
        pushWords(0, 288);
        pushWords(1, 288);
        startRun(1'b1, "rst");
        for (int i = 0; i < 300; i++) sendBit(bits[i]);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstMid_out", {weA, busyA, doneA, toA}, 0);
        chk("rstMid_data", dataA, 0);
        chk("rstMid_busyB", busyB, 0);
`ifdef READBACK_CRC_EN
        chk("rstMid_crc", crcA, 0);
`endif
        for (int i = 0; i < 20; i++) sendBit(1'b1);
        repeat (10) step();
        chk("rstMid_writesA", nWrA, 18);
        chk("rstMid_writesB", nWrB, 18);
        chk("rstMid_left", qA.size() + qB.size(), 0);
        chk("rstMid_done", nDoneA + nDoneB, 0);
        chk("rstMid_idle", {busyA, busyB}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/slow_control_readback.md
# slow_control_readback

Receive side of the MICROROC selected-register path. Samples the chip's serial return line (SR_OUT) on each SR_CK rising edge while a slow-control or read-scope load is shifted in. Packs the returned bits MSB-first into 16-bit words and pushes them to an external FIFO, so software can compare the read-back stream with the written one. Sits beside the parameter shift-out logic, sharing its SR_CK/SR_RSTB pins as inputs, in the Clk domain.

## Interface

**Parameters**
- `SC_BITS`, default 592: slow-control register length in bits.
- `RS_BITS`, default 64: read-scope register length in bits.
- `TIMEOUT_CYCLES`, default 4096: Clk cycles allowed without an SR_CK rising edge while shifting.

**Ports**
- `Clk`  in  1: system clock; must be ≥4× the SR_CK frequency.
- `reset`  in  1: synchronous, active-high.
- `SlowControlOrReadScopeSelect`  in  1: 1 = slow control (`SC_BITS`), 0 = read scope (`RS_BITS`); latched at start.
- `ReadbackStart`  in  1: one-cycle pulse that arms capture.
- `SerialClock`  in  1: SR_CK pin copy; asynchronous.
- `SerialReset`  in  1: SR_RSTB pin copy, active-low; asynchronous.
- `SerialDataIn`  in  1: SR_OUT from chip; asynchronous.
- `ExternalFifoWriteEn`  out  1: one-cycle write strobe.
- `ExternalFifoData`  out  16: packed word, first received bit in [15].
- `ReadbackBusy`  out  1: high from accepted start until done/timeout.
- `ReadbackDone`  out  1: one-cycle pulse after the last word is written.
- `ReadbackTimeout`  out  1: one-cycle pulse on watchdog expiry.
- `ReadbackCrc`  out  16: present only with `READBACK_CRC_EN`.

## Operation

- **Synchronisers.** `SerialClock`, `SerialReset` and `SerialDataIn` each pass through a 2-flop synchroniser. A rising edge = synchronised SR_CK was 0 last cycle and 1 now. Data is sampled from synchronised `SerialDataIn` in the edge-detect cycle.
- **States:** IDLE, SHIFT, FLUSH, DONE.
- **IDLE**
  - `ReadbackStart` → latch the target length N from the select input, clear the bit counter, shift register and watchdog, go to SHIFT.
- **SHIFT**
  - On each rising edge: shift the bit into the LSB of a 16-bit register, increment the bit counter and the in-word counter, clear the watchdog.
  - When the in-word counter wraps 15→0: present the word on `ExternalFifoData` and strobe `ExternalFifoWriteEn` next cycle.
  - When the bit counter reaches N: go to FLUSH.
  - Synchronised `SerialReset` low: clear the bit counter, in-word counter, shift register and CRC; stay in SHIFT. No word is written.
  - Watchdog reaching `TIMEOUT_CYCLES`: pulse `ReadbackTimeout`, go to IDLE. A partial word is discarded.
- **FLUSH**
  - If N mod 16 ≠ 0: write the partial word left-aligned, zero-padded in the LSBs.
  - Then go to DONE.
- **DONE**
  - Pulse `ReadbackDone`, go to IDLE.
- **Edge cases**
  - `ReadbackStart` while busy is ignored.
  - Rising edges in IDLE are ignored.
  - `reset` in any state returns to IDLE in the next cycle and aborts any in-flight write.
- **Counter widths:** bit counter is ⌈log2(max(SC_BITS, RS_BITS)+1)⌉ bits; watchdog is ⌈log2(TIMEOUT_CYCLES+1)⌉ bits.

## Timing

- **Reset values:** all outputs 0; `ReadbackCrc` = 0x0000.
- **Edge to shift:** SR_CK pin rise → 3 Clk cycles to the bit being shifted (2 synchroniser + 1 edge register).
- **Start to busy:** `ReadbackBusy` rises the cycle after `ReadbackStart`.
- **Write strobe:** `ExternalFifoWriteEn` is high 1 cycle after the 16th bit of a word is shifted. `ExternalFifoData` is stable in that cycle.
- **Done, whole words:** when N mod 16 = 0, `ReadbackDone` pulses 2 cycles after the final bit shift. `ReadbackBusy` falls in the same cycle.
- **Done, partial word:** the flush write takes 1 cycle and `ReadbackDone` follows 1 cycle later.
- **Back-pressure:** the external FIFO must accept every strobe; there is no full input.

## Configuration

- **`READBACK_CRC_EN` defined:**
  - CRC-16-CCITT (polynomial 0x1021, init 0x0000, no reflection, no xor-out) is updated on every sampled bit.
  - `ReadbackCrc` holds the final value from DONE until the next accepted start, which clears it.
  - `SerialReset` low in SHIFT also clears it.
- **Not defined:** the `ReadbackCrc` port and CRC logic are absent. All other behaviour is identical.

## Test plan

- **Slow control, alternating data:** select=1, start, 592 SR_CK edges with data 1,0,1,0… → exactly 37 writes of 0xAAAA, `ReadbackDone` 2 cycles after the last shift, no timeout.
- **Read scope, all ones:** select=0, 64 edges of all ones → 4 writes of 0xFFFF, then done. With `READBACK_CRC_EN` and 64 zero bits instead, `ReadbackCrc` = 0x0000.
- **Partial word:** `RS_BITS`=20, bits 0xABCDE MSB-first → writes 0xABCD then 0xE000, then done.
- **Reset pulse mid-shift:** SR_RSTB low after 10 bits, then 592 bits of all zeros → 37 writes of 0x0000 only. The first 10 bits never appear.
- **Watchdog:** start, 5 edges, then SR_CK idle → `ReadbackTimeout` pulses 4096 cycles after the 5th edge, no write, `ReadbackBusy` = 0.
- **Start while busy, and reset:** a second `ReadbackStart` at bit 100 → still 37 writes total. `reset` at bit 300 → all outputs 0 next cycle, no further writes.
